hold_arb: RTL and testbench

//   Round-robin scheduler that shares one burst-type datapath between NREQ requesters.

---
 rtl/hold_arb.sv | 160 ++++++++++++++++
 tb/tb_hold_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hold_arb.sv
// hold_arb: round-robin arbiter that holds a one-hot grant for a whole burst
// and drives the shared engine's enable, beat index and last strobe.
module hold_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [CNT_W-1:0] burst_len,
  output logic [NREQ-1:0]  gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             run_en,
  output logic [CNT_W-1:0] beat,
  output logic             last,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    LAST  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
  logic             run_en_reg, run_en_next;
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic             last_reg, last_next;
  logic             busy_reg, busy_next;

  logic             win_valid;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W:0]    cand_sum;
  logic [NREQ-1:0]  win_onehot;
  logic             winner_req;
  logic [CNT_W-1:0] beat_inc;

  // Rotating priority search: scan offsets from high to low so the smallest
  // offset from ptr (highest priority) is the one left standing.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NREQ))
        cand_sum = cand_sum - (ID_W+1)'(NREQ);
      if (req[cand_sum[ID_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand_sum[ID_W-1:0];
      end
    end
  end

  // One-hot decode of the search result.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == ID_W'(gi));
    end
  endgenerate

  // The held winner's own request decides early abort; others are ignored.
  assign winner_req = req[gnt_id_reg];
  assign beat_inc   = beat_reg + CNT_W'(1);

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    len_next    = len_reg;
    gnt_next    = gnt_reg;
    gnt_id_next = gnt_id_reg;
    run_en_next = 1'b0;
    beat_next   = '0;
    last_next   = 1'b0;
    busy_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (win_valid) begin
          state_next  = GRANT;
          // A zero-length request still gets one beat.
          len_next    = (burst_len == '0) ? CNT_W'(1) : burst_len;
          gnt_next    = win_onehot;
          gnt_id_next = win_idx;
          busy_next   = 1'b1;
        end
      end
      GRANT: begin
        busy_next   = 1'b1;
        run_en_next = 1'b1;
        if (len_reg == CNT_W'(1) || !winner_req) begin
          state_next = LAST;
          last_next  = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy_next   = 1'b1;
        run_en_next = 1'b1;
        beat_next   = beat_inc;
        // Abort still yields one final LAST beat, so the engine always
        // sees a terminating strobe.
        if (beat_inc == len_reg - CNT_W'(1) || !winner_req) begin
          state_next = LAST;
          last_next  = 1'b1;
        end
      end
      LAST: begin
        state_next = IDLE;
        gnt_next   = '0;
        ptr_next   = (gnt_id_reg == ID_W'(NREQ - 1)) ? '0 : gnt_id_reg + ID_W'(1);
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State and output registers; reset overrides any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      len_reg    <= '0;
      gnt_reg    <= '0;
      gnt_id_reg <= '0;
      run_en_reg <= 1'b0;
      beat_reg   <= '0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      len_reg    <= len_next;
      gnt_reg    <= gnt_next;
      gnt_id_reg <= gnt_id_next;
      run_en_reg <= run_en_next;
      beat_reg   <= beat_next;
      last_reg   <= last_next;
      busy_reg   <= busy_next;
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign run_en = run_en_reg;
  assign beat   = beat_reg;
  assign last   = last_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_hold_arb.sv
// tb_hold_arb: directed stimulus, a burst-schedule reference model checked
// every cycle, and hand-computed literal checks on key cycles.
module tb_hold_arb;
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [CNT_W-1:0] burst_len;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             run_en;
  logic [CNT_W-1:0] beat;
  logic             last;
  logic             busy;

  int tests = 0;
  int fails = 0;

  hold_arb #(.NREQ(NREQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .burst_len(burst_len),
    .gnt(gnt), .gnt_id(gnt_id), .run_en(run_en), .beat(beat),
    .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: a burst is a schedule ----------------
  // k = cycles since the grant cycle; beat k-1 is driven for k>=1; the burst
  // ends after the beat numbered m_end (L-1, or earlier on abort).
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  int m_k, m_end, m_win, m_ptr, m_gid;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_ptr    <= 0;
      m_gid    <= 0;
      m_k      <= 0;
      m_end    <= 0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_end    <= ((burst_len == 0) ? 1 : int'(burst_len)) - 1;
        m_win    <= pick(req, m_ptr);
        m_gid    <= pick(req, m_ptr);
      end
    end else if (m_k > 0 && m_k - 1 == m_end) begin
      m_active <= 1'b0;
      m_ptr    <= (m_win + 1) % NREQ;
    end else begin
      m_k <= m_k + 1;
      if (!req[m_win]) m_end <= m_k;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_gnt",    32'(gnt),    m_active ? (32'd1 << m_win) : 32'd0);
      chk("m_gnt_id", 32'(gnt_id), 32'(m_gid));
      chk("m_run_en", 32'(run_en), 32'(m_active && m_k > 0));
      chk("m_beat",   32'(beat),   (m_active && m_k > 0) ? 32'(m_k - 1) : 32'd0);
      chk("m_last",   32'(last),   32'(m_active && m_k > 0 && (m_k - 1 == m_end)));
      chk("m_busy",   32'(busy),   32'(m_active));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------
  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] exp_g;

  initial begin
    rst = 1'b1; req = '0; burst_len = '0;
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gnt",  32'(gnt),  32'd0);
    rst = 1'b0;

    // 1: single requester 2, L=3
    req = 4'b0100; burst_len = 4'd3;                 // c0
    tick();
    chk("t1_gnt_c1", 32'(gnt), 32'b0100);
    chk("t1_id_c1",  32'(gnt_id), 32'd2);
    chk("t1_run_c1", 32'(run_en), 32'd0);
    for (int i = 0; i < 3; i++) begin                // c2..c4
      tick();
      chk("t1_run",  32'(run_en), 32'd1);
      chk("t1_beat", 32'(beat), 32'(i));
      chk("t1_last", 32'(last), 32'(i == 2));
      chk("t1_gnt",  32'(gnt), 32'b0100);
    end
    req = '0;
    tick();                                          // c5
    chk("t1_busy_c5", 32'(busy), 32'd0);
    chk("t1_id_c5",   32'(gnt_id), 32'd2);

    // 2: all requesting, L=1, from ptr=0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; burst_len = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_g = 4'b0001 << (i % 4);
      chk("t2_gnt",  32'(gnt), 32'(exp_g));
      chk("t2_id",   32'(gnt_id), 32'(i % 4));
      tick();
      chk("t2_last", 32'(last), 32'd1);
      chk("t2_beat", 32'(beat), 32'd0);
      if (i == 4) req = '0;
      tick();
      chk("t2_idle", 32'(busy), 32'd0);
    end

    // 3: L=0 behaves as L=1 (ptr=1, so requester 0 wins after wrap)
    req = 4'b0001; burst_len = 4'd0;
    tick();
    chk("t3_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("t3_run",  32'(run_en), 32'd1);
    chk("t3_last", 32'(last), 32'd1);
    chk("t3_beat", 32'(beat), 32'd0);
    req = '0;
    tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: L=8, requester 1 drops during beat 2
    req = 4'b0010; burst_len = 4'd8;
    tick();
    chk("t4_gnt", 32'(gnt), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_beat", 32'(beat), 32'(i));
      chk("t4_last", 32'(last), 32'd0);
    end
    req = '0;
    tick();
    chk("t4_abort_beat", 32'(beat), 32'd3);
    chk("t4_abort_last", 32'(last), 32'd1);
    tick();
    chk("t4_idle", 32'(run_en), 32'd0);

    // 5: reset during RUN beat 4, then grant restarts from ptr=0
    req = 4'b1000; burst_len = 4'd8;
    tick();
    chk("t5_id", 32'(gnt_id), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_beat", 32'(beat), 32'(i));
    end
    rst = 1'b1;
    tick();
    chk("t5_rst_gnt",  32'(gnt), 32'd0);
    chk("t5_rst_id",   32'(gnt_id), 32'd0);
    chk("t5_rst_run",  32'(run_en), 32'd0);
    chk("t5_rst_beat", 32'(beat), 32'd0);
    chk("t5_rst_last", 32'(last), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; req = 4'b1111; burst_len = 4'd1;
    tick();
    chk("t5_ptr0_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick(); tick();
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: L=15, burst_len changed mid-burst; ptr=1 so requester 2 wins
    req = 4'b0100; burst_len = 4'd15;
    tick();
    chk("t6_gnt", 32'(gnt), 32'b0100);
    burst_len = 4'd2;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t6_beat", 32'(beat), 32'(i));
      chk("t6_last", 32'(last), 32'(i == 14));
    end
    req = '0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_beat0", 32'(beat), 32'd0);

    // 7: winner drops in GRANT -> LAST with beat 0; others held are ignored
    req = 4'b1001; burst_len = 4'd5;
    tick();
    chk("t7_gnt", 32'(gnt), 32'b1000);
    req = 4'b0001;
    tick();
    chk("t7_last", 32'(last), 32'd1);
    chk("t7_beat", 32'(beat), 32'd0);
    chk("t7_gnt_held", 32'(gnt), 32'b1000);
    req = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
